// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the three-requester memory port arbiter.
// Holds the FSM state encoding, requester indices and an index-to-one-hot helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    localparam logic [1:0] REQ_IFETCH = 2'd0;
    localparam logic [1:0] REQ_DMEM   = 2'd1;
    localparam logic [1:0] REQ_PTW    = 2'd2;

    // Index 3 never names a requester, so it maps to no strobe at all.
    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b000;
        case (idx)
            REQ_IFETCH: oh = 3'b001;
            REQ_DMEM:   oh = 3'b010;
            REQ_PTW:    oh = 3'b100;
            default:    oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Combinational round-robin picker over three requesters.
// The search starts just after the previous owner and wraps modulo 3.
module rr_pick3
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = REQ_IFETCH;
        case (last)
            REQ_IFETCH: begin
                if (req[1])      idx = REQ_DMEM;
                else if (req[2]) idx = REQ_PTW;
                else if (req[0]) idx = REQ_IFETCH;
            end
            REQ_DMEM: begin
                if (req[2])      idx = REQ_PTW;
                else if (req[0]) idx = REQ_IFETCH;
                else if (req[1]) idx = REQ_DMEM;
            end
            // last == REQ_PTW (and the unused code 3) restart the search at 0.
            default: begin
                if (req[0])      idx = REQ_IFETCH;
                else if (req[1]) idx = REQ_DMEM;
                else if (req[2]) idx = REQ_PTW;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates I-fetch, D-access and page-walker requests onto one memory port.
// One transaction at a time: IDLE -> REQ (hold valid until ready) -> WAIT_RESP.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_req,
    output logic [2:0] o_gnt,
    output logic [1:0] o_sel,
    output logic       o_mem_valid,
    input  logic       i_mem_ready,
    input  logic       i_mem_resp_valid,
    output logic [2:0] o_resp_valid,
    output logic       o_busy,
    output logic       o_err
);

    // The counter reads N-1 during the N-th WAIT_RESP cycle, so expiry is the last one.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [1:0]           owner_q, owner_d;
    logic [1:0]           last_owner_q, last_owner_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 pick_valid;
    logic [1:0]           pick_idx;
    logic                 expire;

    rr_pick3 u_rr_pick3 (
        .req   (i_req),
        .last  (last_owner_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign expire = (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            owner_q      <= REQ_IFETCH;
            last_owner_q <= REQ_PTW;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (i_mem_resp_valid) err_d = 1'b1;
                if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (i_mem_resp_valid) err_d = 1'b1;
                if (i_mem_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                cnt_d = cnt_q + CNT_ONE;
                // A response on the expiry cycle wins over the timeout.
                if (i_mem_resp_valid) begin
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end else if (expire) begin
                    err_d        = 1'b1;
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_gnt        = 3'b000;
        o_sel        = 2'd0;
        o_mem_valid  = 1'b0;
        o_resp_valid = 3'b000;
        case (state_q)
            REQ: begin
                o_mem_valid = 1'b1;
                o_sel       = owner_q;
                if (i_mem_ready) o_gnt = idx_to_onehot(owner_q);
            end
            WAIT_RESP: begin
                o_sel = owner_q;
                if (i_mem_resp_valid) o_resp_valid = idx_to_onehot(owner_q);
            end
            default: ;
        endcase
    end

    assign o_busy = (state_q != IDLE);
    assign o_err  = err_q;

endmodule
